ppi_bus_ctrl: RTL and testbench

CPU-side bus interface and register file of the PPI. It synchronises the asynchronous 8255-style strobes and decodes A1/A0. It holds the mode control word and the port A/B/C output latches. For control-register writes with D7=0 it forwards the byte to the BSR stage as bsr_control with a one-cycle strobe, and applies the same bit set/reset to its port C latch. It also drives the read-data bus.

---
 rtl/ppi_pkg.sv | 25 ++
 rtl/ppi_sync.sv | 21 ++
 rtl/ppi_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_ppi_bus_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared constants and types for the PPI CPU bus interface.
// Address map, FSM state encoding, reset mode word and mode-word bit positions.
package ppi_pkg;

  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam logic [7:0] MODE_RESET = 8'h9B;

  // Bit positions inside the mode control word
  localparam int PA_IN     = 4;
  localparam int PB_IN     = 1;
  localparam int PCU_IN    = 3;
  localparam int PCL_IN    = 0;
  localparam int MODE_FLAG = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/ppi_sync.sv
// Multi-flop synchroniser for one asynchronous active-low strobe.
// Flops preset to 1 on reset so the strobe reads as inactive.
module ppi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ppi_bus_ctrl.sv
// PPI CPU bus interface: strobe sync, write/read FSM, mode word and port latches.
// Define PPI_READBACK_EN to make a control-address read return mode_word instead of 8'hFF.
module ppi_bus_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MODE_RESET  = ppi_pkg::MODE_RESET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] port_a_out,
  output logic [7:0] port_b_out,
  output logic [7:0] port_c_out,
  output logic [7:0] mode_word,
  output logic [7:0] bsr_control,
  output logic       bsr_strobe
);

  import ppi_pkg::*;

  logic       cs_s, rd_s, wr_s;
  logic [1:0] addr_w;
  logic [7:0] din_w;
  logic [7:0] rd_data;
  logic       commit;
  state_t     state_q, state_d;

  ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst(rst), .d(cs_n), .q(cs_s));
  ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .rst(rst), .d(rd_n), .q(rd_s));
  ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .rst(rst), .d(wr_n), .q(wr_s));

  // Track addr/din while WR is low so the last value before WR rises is committed
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_w <= '0;
      din_w  <= '0;
    end else if (!wr_s) begin
      addr_w <= addr;
      din_w  <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s && !wr_s)      state_d = WRITE;
        else if (!cs_s && !rd_s) state_d = READ;
      end
      WRITE: begin
        if (wr_s) begin
          state_d = IDLE;
          commit  = !cs_s;
        end
      end
      READ: begin
        if (rd_s || cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_PA: rd_data = mode_word[PA_IN] ? pa_in : port_a_out;
      ADDR_PB: rd_data = mode_word[PB_IN] ? pb_in : port_b_out;
      ADDR_PC: rd_data = {mode_word[PCU_IN] ? pc_in[7:4] : port_c_out[7:4],
                          mode_word[PCL_IN] ? pc_in[3:0] : port_c_out[3:0]};
`ifdef PPI_READBACK_EN
      ADDR_CTRL: rd_data = mode_word;
`else
      ADDR_CTRL: rd_data = 8'hFF;
`endif
      default: rd_data = 8'h00;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_word   <= MODE_RESET;
      port_a_out  <= '0;
      port_b_out  <= '0;
      port_c_out  <= '0;
      bsr_control <= '0;
      bsr_strobe  <= 1'b0;
      dout        <= '0;
    end else begin
      bsr_strobe <= 1'b0;
      if (commit) begin
        case (addr_w)
          ADDR_PA: port_a_out <= din_w;
          ADDR_PB: port_b_out <= din_w;
          ADDR_PC: port_c_out <= din_w;
          ADDR_CTRL: begin
            if (din_w[MODE_FLAG]) begin
              mode_word  <= din_w;
              port_a_out <= '0;
              port_b_out <= '0;
              port_c_out <= '0;
            end else begin
              bsr_control                <= din_w;
              bsr_strobe                 <= 1'b1;
              port_c_out[din_w[3:1]]     <= din_w[0];
            end
          end
          default: ;
        endcase
      end
      if (state_q == READ) dout <= rd_data;
    end
  end

  assign dout_en = (state_q == READ);

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Directed self-checking bench for ppi_bus_ctrl (default SYNC_STAGES=2).
// Expected values are hand-computed; PPI_READBACK_EN selects the control-read expectation.
module tb_ppi_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;
  logic [7:0] pa_in, pb_in, pc_in;
  logic [7:0] port_a_out, port_b_out, port_c_out;
  logic [7:0] mode_word, bsr_control;
  logic       bsr_strobe;

  int checks   = 0;
  int failures = 0;

  ppi_bus_ctrl dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .din(din), .dout(dout), .dout_en(dout_en),
    .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .port_a_out(port_a_out), .port_b_out(port_b_out), .port_c_out(port_c_out),
    .mode_word(mode_word), .bsr_control(bsr_control), .bsr_strobe(bsr_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive WR low with CS held, then raise WR on the pin; returns at the rise
  task automatic wr_start(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; addr = a; din = d; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
  endtask

  task automatic wr_end();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_full(input logic [1:0] a, input logic [7:0] d);
    wr_start(a, d);
    repeat (3) @(posedge clk);
    wr_end();
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 2'b00; din = 8'h00;
    pa_in = 8'h5A; pb_in = 8'hC3; pc_in = 8'h3C;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mode", mode_word, 8'h9B);
    check("rst_pa", port_a_out, 8'h00);
    check("rst_pb", port_b_out, 8'h00);
    check("rst_pc", port_c_out, 8'h00);
    check("rst_bsr_ctl", bsr_control, 8'h00);
    check("rst_bsr_stb", {7'd0, bsr_strobe}, 8'h00);
    check("rst_dout_en", {7'd0, dout_en}, 8'h00);
    check("rst_dout", dout, 8'h00);

    // Port B write with exact SYNC_STAGES+1 commit latency
    wr_start(2'b01, 8'hA5);
    repeat (2) @(posedge clk); #1;
    check("pb_early", port_b_out, 8'h00);
    @(posedge clk); #1;
    check("pb_commit", port_b_out, 8'hA5);
    wr_end();

    // BSR set bit 5, then reset it
    write_full(2'b10, 8'h00);
    wr_start(2'b11, 8'h0B);
    repeat (3) @(posedge clk); #1;
    check("bsr_ctl_set", bsr_control, 8'h0B);
    check("bsr_stb_hi", {7'd0, bsr_strobe}, 8'h01);
    check("bsr_pc_set", port_c_out, 8'h20);
    check("bsr_mode_kept", mode_word, 8'h9B);
    @(posedge clk); #1;
    check("bsr_stb_lo", {7'd0, bsr_strobe}, 8'h00);
    wr_end();
    wr_start(2'b11, 8'h0A);
    repeat (3) @(posedge clk); #1;
    check("bsr_ctl_clr", bsr_control, 8'h0A);
    check("bsr_pc_clr", port_c_out, 8'h00);
    wr_end();

    // Mode set clears all latches, no BSR strobe
    write_full(2'b00, 8'hFF);
    write_full(2'b01, 8'hFF);
    write_full(2'b10, 8'hFF);
    check("pre_mode_pc", port_c_out, 8'hFF);
    wr_start(2'b11, 8'h80);
    repeat (3) @(posedge clk); #1;
    check("mode_set", mode_word, 8'h80);
    check("mode_pa_clr", port_a_out, 8'h00);
    check("mode_pb_clr", port_b_out, 8'h00);
    check("mode_pc_clr", port_c_out, 8'h00);
    check("mode_no_stb", {7'd0, bsr_strobe}, 8'h00);
    check("mode_bsr_kept", bsr_control, 8'h0A);
    wr_end();

    // Read mux: mode 88 -> PA out, PCU in, PB out, PCL out
    write_full(2'b11, 8'h88);
    write_full(2'b10, 8'h05);
    write_full(2'b00, 8'h11);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; addr = 2'b10;
    repeat (5) @(posedge clk); #1;
    check("rd_en", {7'd0, dout_en}, 8'h01);
    check("rd_pc", dout, 8'h35);
    @(negedge clk); addr = 2'b11;
    @(posedge clk); #1;
`ifdef PPI_READBACK_EN
    check("rd_ctrl", dout, 8'h88);
`else
    check("rd_ctrl", dout, 8'hFF);
`endif
    @(negedge clk); addr = 2'b00;
    @(posedge clk); #1;
    check("rd_pa_latch", dout, 8'h11);
    @(negedge clk); rd_n = 1'b1; cs_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("rd_end_en", {7'd0, dout_en}, 8'h00);
    check("rd_end_hold", dout, 8'h11);

    // Simultaneous RD and WR is a write
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h77;
    repeat (5) @(posedge clk); #1;
    check("rw_no_read", {7'd0, dout_en}, 8'h00);
    @(negedge clk); wr_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rw_commit", port_b_out, 8'h77);
    wr_end();

    // CS released before WR rises: write aborted
    @(negedge clk);
    cs_n = 1'b0; addr = 2'b00; din = 8'h99; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    wr_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("abort_pa", port_a_out, 8'h11);
    check("abort_mode", mode_word, 8'h88);

    // Reset while in WRITE: no commit, everything back to reset
    @(negedge clk);
    cs_n = 1'b0; addr = 2'b01; din = 8'h3C; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    wr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("rstw_pb", port_b_out, 8'h00);
    check("rstw_pa", port_a_out, 8'h00);
    check("rstw_pc", port_c_out, 8'h00);
    check("rstw_mode", mode_word, 8'h9B);
    check("rstw_bsr", bsr_control, 8'h00);
    check("rstw_dout", dout, 8'h00);
    check("rstw_dout_en", {7'd0, dout_en}, 8'h00);
    @(negedge clk); cs_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
